// File: rtl/cmd_link_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_link_scheduler_pkg
// Purpose  : Shared definitions for the UART command-link scheduler: frame
//            layout, command bit positions, requester indices, FSM encoding
//            and the command sanitiser.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmd_link_scheduler_pkg;

  localparam logic [1:0] FRAME_HDR  = 2'b10;
  localparam logic [7:0] STOP_FRAME = 8'h80;

  localparam int CMD_W       = 6;
  localparam int CMD_FWD     = 0;
  localparam int CMD_BACK    = 1;
  localparam int CMD_LEFT    = 2;
  localparam int CMD_RIGHT   = 3;
  localparam int CMD_PLACE   = 4;
  localparam int CMD_DESTROY = 5;

  localparam int NUM_REQ    = 3;
  localparam int REQ_MANUAL = 0;
  localparam int REQ_SEMI   = 1;
  localparam int REQ_AUTO   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Contradictory pairs cancel to "neither" rather than picking a winner.
  function automatic logic [CMD_W-1:0] sanitise_cmd(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] res;
    res = cmd;
    if (cmd[CMD_FWD] && cmd[CMD_BACK]) begin
      res[CMD_FWD]  = 1'b0;
      res[CMD_BACK] = 1'b0;
    end
    if (cmd[CMD_LEFT] && cmd[CMD_RIGHT]) begin
      res[CMD_LEFT]  = 1'b0;
      res[CMD_RIGHT] = 1'b0;
    end
    if (cmd[CMD_PLACE] && cmd[CMD_DESTROY]) begin
      res[CMD_PLACE]   = 1'b0;
      res[CMD_DESTROY] = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_link_scheduler_link_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : link_watchdog
// Purpose  : Counts frame slots without a received byte, derives link_ok and
//            latches detector replies (forced to all-blocked while lost).
// Ports    : clk_i, rst_i      - clock, synchronous active-high reset
//            tick_i            - one-cycle frame slot strobe
//            rx_det_i[3:0]     - received detector bits {back,right,left,front}
//            rx_valid_i        - received byte strobe
//            link_ok_o         - reply seen within the last TIMEOUT_FRAMES slots
//            detectors_o[3:0]  - latched detectors, 4'b1111 while link lost
// Revision : 1.0 - initial release
// ============================================================================
module link_watchdog #(
  parameter int unsigned TIMEOUT_FRAMES = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [3:0] rx_det_i,
  input  logic       rx_valid_i,
  output logic       link_ok_o,
  output logic [3:0] detectors_o
);

  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(TIMEOUT_FRAMES);

  logic [MISS_W-1:0] miss_q;
  logic              seen_q;
  logic [3:0]        det_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_q <= '0;
      seen_q <= 1'b0;
      det_q  <= 4'b1111;
    end else begin
      // A reply in the same cycle as a tick takes precedence.
      if (rx_valid_i) begin
        miss_q <= '0;
        seen_q <= 1'b1;
        det_q  <= rx_det_i;
      end else if (tick_i && (miss_q != MISS_MAX)) begin
        miss_q <= miss_q + 1'b1;
      end
    end
  end

  // miss saturates at MISS_MAX, so "!=" is the same as "<".
  assign link_ok_o   = seen_q && (miss_q != MISS_MAX);
  assign detectors_o = link_ok_o ? det_q : 4'b1111;

endmodule
`default_nettype wire

// File: rtl/cmd_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cmd_link_scheduler
// Purpose  : Periodic command-frame scheduler/arbiter for the UART link.
//            Each slot it picks one of three requesters (sticky owner,
//            otherwise manual > semi-auto > auto), sanitises and frames its
//            command and offers it to the transmitter with valid/ready.
//            A link watchdog forces stop frames when replies cease.
// Ports    : sys_clk_i, rst_i     - clock, synchronous active-high reset
//            req_valid_i[2:0]     - requester wants the link
//            req_cmd_i[17:0]      - per-requester 6-bit commands
//            grant_o[2:0]         - one-hot current owner
//            tx_data_o/valid_o    - frame byte and valid to transmitter
//            tx_ready_i           - transmitter accepts the byte
//            rx_data_i/valid_i    - detector reply byte and strobe
//            detectors_o[3:0]     - latched {back,right,left,front}
//            link_ok_o            - link alive
//            frame_sent_o         - pulse on accepted handshake
//            overrun_o            - sticky: a slot tick was dropped
// Revision : 1.0 - initial release
// ============================================================================
module cmd_link_scheduler
  import cmd_link_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD   = 100000,
  parameter int unsigned TIMEOUT_FRAMES = 50
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic [2:0]  req_valid_i,
  input  logic [17:0] req_cmd_i,
  output logic [2:0]  grant_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [3:0]  detectors_o,
  output logic        link_ok_o,
  output logic        frame_sent_o,
  output logic        overrun_o
);

  localparam int SLOT_W = $clog2(FRAME_PERIOD);

  // --------------------------------------------------------------------------
  // Slot counter
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_q;
  logic              tick;

  assign tick = (slot_q == SLOT_W'(FRAME_PERIOD - 1));

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else if (tick) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Link watchdog; only the detector nibble of the reply is meaningful.
  // --------------------------------------------------------------------------
  logic       link_ok;
  logic [3:0] unused_rx_hi;

  assign unused_rx_hi = rx_data_i[7:4];

  link_watchdog #(
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
  ) u_link_watchdog (
    .clk_i       (sys_clk_i),
    .rst_i       (rst_i),
    .tick_i      (tick),
    .rx_det_i    (rx_data_i[3:0]),
    .rx_valid_i  (rx_valid_i),
    .link_ok_o   (link_ok),
    .detectors_o (detectors_o)
  );

  assign link_ok_o = link_ok;

  // --------------------------------------------------------------------------
  // Arbitration: the current owner keeps the link while it still asks for it.
  // --------------------------------------------------------------------------
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       arb_grant;
  logic [CMD_W-1:0] arb_cmd;

  always_comb begin
    arb_grant = grant_q;
    if ((grant_q & req_valid_i) == 3'b000) begin
      arb_grant = 3'b000;
      if (req_valid_i[REQ_MANUAL])    arb_grant = 3'b001;
      else if (req_valid_i[REQ_SEMI]) arb_grant = 3'b010;
      else if (req_valid_i[REQ_AUTO]) arb_grant = 3'b100;
    end
  end

  always_comb begin
    arb_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_cmd = req_cmd_i[CMD_W*i +: CMD_W];
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       frame_sent_q, frame_sent_d;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      grant_q      <= 3'b000;
      tx_data_q    <= STOP_FRAME;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    frame_sent_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        grant_d = arb_grant;
        // Grant still moves with arbitration even when a stop is forced.
        if ((arb_grant == 3'b000) || !link_ok) begin
          tx_data_d = STOP_FRAME;
        end else begin
          tx_data_d = {FRAME_HDR, sanitise_cmd(arb_cmd)};
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          state_d      = ST_IDLE;
          frame_sent_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that arrives while busy is remembered once; a second one is lost.
    if (tick && (state_q != ST_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end
  end

  assign grant_o      = grant_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = (state_q == ST_SEND);
  assign frame_sent_o = frame_sent_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_link_scheduler
// Purpose  : Self-checking bench for cmd_link_scheduler with a slot-level
//            reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_link_scheduler;

  localparam int P = 8;
  localparam int T = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = 3'b000;
  logic [17:0] req_cmd = '0;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  detectors;
  logic        link_ok;
  logic        frame_sent;
  logic        overrun;

  always #5 clk = ~clk;

  cmd_link_scheduler #(
    .FRAME_PERIOD   (P),
    .TIMEOUT_FRAMES (T)
  ) dut (
    .sys_clk_i    (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_cmd_i    (req_cmd),
    .grant_o      (grant),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .detectors_o  (detectors),
    .link_ok_o    (link_ok),
    .frame_sent_o (frame_sent),
    .overrun_o    (overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: slot timing, pending slots and link health as plain ints.
  // --------------------------------------------------------------------------
  int         phase = 0;    // cycles into the current slot
  int         stage = 0;    // 0 no frame, 1 frame being built, 2 frame offered
  bit         owed  = 0;    // one slot request remembered while busy
  bit         m_ovr = 0;
  logic [2:0] m_grant = 3'b000;
  logic [7:0] m_data = 8'h80;
  bit         m_sent = 0;
  int         miss = 0;
  bit         seen = 0;
  logic [3:0] det = 4'b1111;

  int         nframes = 0;
  logic [7:0] last_frame = 8'h00;
  logic [2:0] last_grant = 3'b000;

  task automatic model_step();
    bit         tk;
    bit         lk;
    bit         found;
    logic [2:0] g;
    logic [5:0] c;
    if (rst) begin
      phase = 0; stage = 0; owed = 0; m_ovr = 0; m_grant = 3'b000;
      m_data = 8'h80; m_sent = 0; miss = 0; seen = 0; det = 4'b1111;
      return;
    end
    if (tx_valid && tx_ready) begin
      nframes++;
      last_frame = tx_data;
      last_grant = grant;
    end
    tk    = (phase == P - 1);
    phase = (phase + 1) % P;
    lk    = seen && (miss < T);
    m_sent = 0;
    if (stage == 0) begin
      if (tk || owed) begin
        stage = 1;
        owed  = 0;
      end
    end else begin
      if (stage == 1) begin
        if ((m_grant & req_valid) != 3'b000) begin
          g = m_grant;
        end else begin
          g = 3'b000;
          found = 0;
          for (int i = 0; i < 3; i++) begin
            if (!found && req_valid[i]) begin
              g = 3'b001 << i;
              found = 1;
            end
          end
        end
        m_grant = g;
        c = 6'b000000;
        for (int i = 0; i < 3; i++) if (g[i]) c = req_cmd[6*i +: 6];
        if (c[0] && c[1]) c[1:0] = 2'b00;
        if (c[2] && c[3]) c[3:2] = 2'b00;
        if (c[4] && c[5]) c[5:4] = 2'b00;
        m_data = (g == 3'b000 || !lk) ? 8'h80 : {2'b10, c};
        stage = 2;
      end else if (tx_ready) begin
        stage  = 0;
        m_sent = 1;
      end
      if (tk) begin
        if (owed) m_ovr = 1;
        owed = 1;
      end
    end
    if (rx_valid) begin
      miss = 0;
      seen = 1;
      det  = rx_data[3:0];
    end else if (tk && miss < T) begin
      miss++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, stage == 2});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
      chk("grant", {29'd0, grant}, {29'd0, m_grant});
      chk("frame_sent", {31'd0, frame_sent}, {31'd0, m_sent});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("link_ok", {31'd0, link_ok}, {31'd0, seen && miss < T});
      chk("detectors", {28'd0, detectors}, {28'd0, (seen && miss < T) ? det : 4'b1111});
    end
  end

  // --------------------------------------------------------------------------
  // Background replier: one rx byte every two slots while enabled.
  // --------------------------------------------------------------------------
  bit         rx_auto = 0;
  logic [7:0] rx_byte = 8'h00;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      rx_valid = 1'b0;
      if (rx_auto) begin
        if (cnt == 0) begin
          rx_valid = 1'b1;
          rx_data  = rx_byte;
        end
        cnt = (cnt + 1) % (2 * P);
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_frame();
    int start;
    int k;
    start = nframes;
    k = 0;
    while (nframes == start && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    if (nframes == start) begin
      total++;
      bad++;
      $display("FAIL wait_frame: no frame within %0d cycles at %0t", 4 * P, $time);
    end
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!tx_valid && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    if (!tx_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: tx_valid never rose at %0t", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] held;
    int         n0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h80);
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_link_ok", {31'd0, link_ok}, 32'd0);
    chk("rst_detectors", {28'd0, detectors}, 32'hF);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;

    // No requesters, no replies: stop frames every slot
    repeat (3) wait_frame();
    chk("idle_frame", {24'd0, last_frame}, 32'h80);
    chk("idle_grant", {29'd0, last_grant}, 32'd0);
    chk("idle_link_ok", {31'd0, link_ok}, 32'd0);

    // Link comes up, semi-auto drives forward
    rx_byte   = 8'h05;
    rx_auto   = 1;
    req_valid = 3'b010;
    req_cmd   = {6'b000000, 6'b000001, 6'b000000};
    repeat (2) wait_frame();
    chk("semi_frame", {24'd0, last_frame}, 32'h81);
    chk("semi_grant", {29'd0, last_grant}, 32'h2);
    chk("semi_detectors", {28'd0, detectors}, 32'h5);

    // No preemption by manual while semi-auto still asks
    req_valid = 3'b011;
    req_cmd   = {6'b000000, 6'b000001, 6'b000010};
    repeat (2) wait_frame();
    chk("hold_grant", {29'd0, last_grant}, 32'h2);
    chk("hold_frame", {24'd0, last_frame}, 32'h81);

    // Owner drops: manual wins; contradictory pairs cancel
    req_valid = 3'b001;
    req_cmd   = {6'b000000, 6'b000000, 6'b001111};
    repeat (2) wait_frame();
    chk("manual_grant", {29'd0, last_grant}, 32'h1);
    chk("cancel_frame", {24'd0, last_frame}, 32'h80);
    req_cmd = {6'b000000, 6'b000000, 6'b110101};
    repeat (2) wait_frame();
    chk("sanitise_frame", {24'd0, last_frame}, 32'h85);

    // Transmitter stalls for two slots
    tx_ready = 1'b0;
    wait_valid();
    held = tx_data;
    repeat (2 * P) @(negedge clk);
    chk("stall_stable", {24'd0, tx_data}, {24'd0, held});
    chk("stall_overrun", {31'd0, overrun}, 32'd1);
    n0 = nframes;
    tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_extra_frames", nframes - n0, 32'd2);

    // Replies stop: link lost, stop frames despite grant
    rx_auto = 0;
    repeat (6) wait_frame();
    chk("lost_link_ok", {31'd0, link_ok}, 32'd0);
    chk("lost_detectors", {28'd0, detectors}, 32'hF);
    wait_frame();
    chk("lost_frame", {24'd0, last_frame}, 32'h80);
    chk("lost_grant", {29'd0, last_grant}, 32'h1);

    // A single reply restores the link
    rx_byte = 8'h0A;
    rx_auto = 1;
    @(negedge clk);
    rx_auto = 0;
    @(negedge clk);
    chk("resume_link_ok", {31'd0, link_ok}, 32'd1);
    chk("resume_detectors", {28'd0, detectors}, 32'hA);
    repeat (2) wait_frame();
    chk("resume_frame", {24'd0, last_frame}, 32'h85);

    // Reset while a frame is offered
    tx_ready = 1'b0;
    wait_valid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_send_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_send_sent", {31'd0, frame_sent}, 32'd0);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_link_scheduler.md
# cmd_link_scheduler

Periodic command-frame scheduler and arbiter for the car's UART link to the simulator. It shares the single TX command byte between three driving requesters (manual, semi-auto, auto), sanitises and frames the winning command, and hands it to the UART transmitter with a valid/ready handshake at a fixed refresh period. It also latches detector replies and runs a link watchdog that forces a safe stop frame when replies cease. It sits between the driving-mode logic and `uart_top`.

## Interface
- `FRAME_PERIOD`, 100000, sys_clk cycles between frame slots (1 ms at 100 MHz); ≥ 4
- `TIMEOUT_FRAMES`, 50, frame slots without any rx byte before link is declared lost; ≥ 1
- `sys_clk`  in  1  system clock (100 MHz); single clock domain
- `rst`  in  1  reset; one clock, synchronous, active-high
- `req_valid`  in  3  requester wants the link; bit0 manual, bit1 semi-auto, bit2 auto
- `req_cmd`  in  18  three 6-bit commands, requester i at [6i+5:6i], each {destroy, place, right, left, back, fwd}
- `grant`  out  3  one-hot current owner, 0 when none
- `tx_data`  out  8  frame byte {2'b10, destroy, place, right, left, back, fwd}
- `tx_valid`  out  1  frame pending for transmitter
- `tx_ready`  in  1  transmitter accepts byte this cycle
- `rx_data`  in  8  received detector byte; [0] front, [1] left, [2] right, [3] back
- `rx_valid`  in  1  one-cycle strobe, rx_data valid
- `detectors`  out  4  latched {back, right, left, front}
- `link_ok`  out  1  reply seen within last TIMEOUT_FRAMES slots
- `frame_sent`  out  1  one-cycle pulse on accepted handshake
- `overrun`  out  1  sticky: a slot tick was dropped

## Operation
- Slot counter free-runs 0..FRAME_PERIOD-1; `tick` when it equals FRAME_PERIOD-1.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: on tick or `pending` set → LOAD; clear `pending`.
  - LOAD (one cycle): arbitrate, build frame into `tx_data` → SEND.
  - SEND: `tx_valid`=1; on `tx_ready` → IDLE, pulse `frame_sent`.
- Tick while in LOAD/SEND: set `pending`; if `pending` already set, set `overrun` (cleared only by rst).
- Arbitration in LOAD: if current owner's `req_valid` still high, owner keeps grant (no preemption). Otherwise grant highest-priority valid requester (bit0 > bit1 > bit2); none valid → `grant`=0.
- Sanitise granted command: fwd&back both 1 → both 0; left&right both 1 → both 0; place&destroy both 1 → both 0.
- Frame = {2'b10, sanitised cmd}. Forced to 8'h80 (stop) when `grant`=0 or `link_ok`=0; grant still updates.
- Watchdog: `miss` counter increments on each tick, saturates at TIMEOUT_FRAMES; rx_valid clears it to 0 (rx wins if same cycle as tick). `link_ok` = rx seen since rst and `miss` < TIMEOUT_FRAMES.
- On rx_valid: `detectors` ← {rx_data[3], rx_data[2], rx_data[1], rx_data[0]}. While `link_ok`=0, `detectors` reads 4'b1111 (all blocked, safe).
- Stop frames keep being sent while link is lost, so the simulator can resume replying.

## Timing
- Reset values: state IDLE, counters 0, `grant` 0, `tx_data` 8'h80, `tx_valid` 0, `detectors` 4'b1111, `link_ok` 0, `frame_sent` 0, `overrun` 0, `pending` 0.
- Tick in cycle T → LOAD T+1 → `tx_valid` high from T+2; `tx_ready` high at T+2 → `frame_sent` at T+3, `tx_valid` low at T+3.
- `tx_data` and `grant` stable while `tx_valid`=1 and `tx_ready`=0; requester changes during SEND affect only the next slot.
- `detectors`/`link_ok` update the cycle after rx_valid.
- rst mid-SEND: `tx_valid` drops next cycle, no `frame_sent`.

## Structure
- Shared package: frame header 2'b10, stop frame 8'h80, command bit indices (FWD=0 … DESTROY=5), requester indices, FSM state encoding.
- One natural sub-module: `link_watchdog` (miss counter, `link_ok`, detector latch/force).

## Test plan
- Reset, no requesters, tx_ready tied 1 → frame 8'h80 every FRAME_PERIOD cycles, `grant`=0, `link_ok`=0, `detectors`=4'b1111.
- rx_valid with 8'h05, then req_valid=3'b010, cmd1=6'b000001 → next frame 8'h81, `grant`=3'b010, `detectors`=4'b0101.
- Owner bit1 held, bit0 raised → bit1 keeps grant; drop bit1 → next slot `grant`=3'b001.
- cmd0=6'b001111 → frame 8'h80 (fwd/back and left/right cancel); cmd0=6'b110101 → 8'h85.
- tx_ready held 0 for 2·FRAME_PERIOD → `tx_data` stable, `overrun`=1, exactly one extra frame after release.
- Stop rx for TIMEOUT_FRAMES slots → `link_ok`=0, frames 8'h80 despite grant; single rx_valid → `link_ok`=1 next cycle, commands resume.
